// File: rtl/cute_key_sequencer.sv
// Serial-loaded four-slot key store with a LOAD/RUN/HOLD sequencer stepping through the slots.
// Optional build macro KEYSEQ_GRAY_EN: slot index steps in Gray order instead of binary.
module cute_key_sequencer #(
    parameter int NSLOT = 4,
    parameter int KW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic          load_bit,
    output logic          load_ready,
    output logic          load_done,
    input  logic          step_en,
    input  logic          pause,
    output logic [KW-1:0] key_out,
    output logic [1:0]    slot_idx,
    output logic          key_valid
);

    localparam int SW = NSLOT * KW;
    localparam logic [3:0] LAST_BIT = 4'(SW - 1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    bitCnt_q, bitCnt_d;
    logic [SW-1:0] keyStore_q, keyStore_d;
    logic [1:0]    slotIdx_q, slotIdx_d;
    logic          loadDone_q, loadDone_d;
    logic [1:0]    slotNext;
    logic [KW-1:0] curKey;

`ifdef KEYSEQ_GRAY_EN
    always_comb begin
        case (slotIdx_q)
            2'b00:   slotNext = 2'b01;
            2'b01:   slotNext = 2'b11;
            2'b11:   slotNext = 2'b10;
            default: slotNext = 2'b00;
        endcase
    end
`else
    always_comb begin
        slotNext = slotIdx_q + 2'd1;
    end
`endif

    // load_start outranks everything; a bit offered alongside it is dropped.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        keyStore_d = keyStore_q;
        slotIdx_d  = slotIdx_q;
        loadDone_d = 1'b0;
        if (load_start) begin
            state_d   = ST_LOAD;
            bitCnt_d  = 4'd0;
            slotIdx_d = 2'd0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_valid) begin
                        for (int i = 0; i < SW; i++) begin
                            if (bitCnt_q == 4'(i)) begin
                                keyStore_d[i] = load_bit;
                            end
                        end
                        if (bitCnt_q == LAST_BIT) begin
                            state_d    = ST_RUN;
                            bitCnt_d   = 4'd0;
                            slotIdx_d  = 2'd0;
                            loadDone_d = 1'b1;
                        end else begin
                            bitCnt_d = bitCnt_q + 4'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_HOLD;
                    end else if (step_en) begin
                        slotIdx_d = slotNext;
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d  = ST_LOAD;
                    bitCnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            bitCnt_q   <= 4'd0;
            keyStore_q <= '0;
            slotIdx_q  <= 2'd0;
            loadDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            keyStore_q <= keyStore_d;
            slotIdx_q  <= slotIdx_d;
            loadDone_q <= loadDone_d;
        end
    end

    always_comb begin
        curKey = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slotIdx_q == 2'(i)) begin
                curKey = keyStore_q[i*KW +: KW];
            end
        end
    end

    assign load_ready = (state_q == ST_LOAD);
    assign key_valid  = (state_q != ST_LOAD);
    assign load_done  = loadDone_q;
    assign slot_idx   = slotIdx_q;
    assign key_out    = key_valid ? curKey : '0;

endmodule

// File: tb/tb_cute_key_sequencer.sv
// Scoreboard bench for cute_key_sequencer: each driven cycle queues the expected outputs,
// which are popped and compared one step after the following rising edge.
module tb_cute_key_sequencer;

    typedef struct {
        string      tag;
        logic [1:0] slot;
        logic [2:0] key;
        logic       valid;
        logic       done;
        logic       ready;
    } expT;

    logic       clock;
    logic       reset;
    logic       loadStart;
    logic       loadValid;
    logic       loadBit;
    logic       loadReady;
    logic       loadDone;
    logic       stepEn;
    logic       pause;
    logic [2:0] keyOut;
    logic [1:0] slotIdx;
    logic       keyValid;

    expT        sbQ[$];
    int         checkCount;
    int         errorCount;
    int         pos;
    logic [2:0] curKeys [4];
    logic [1:0] orderTbl [4];

    cute_key_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (loadStart),
        .load_valid (loadValid),
        .load_bit   (loadBit),
        .load_ready (loadReady),
        .load_done  (loadDone),
        .step_en    (stepEn),
        .pause      (pause),
        .key_out    (keyOut),
        .slot_idx   (slotIdx),
        .key_valid  (keyValid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drainScoreboard();
        expT e;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({e.tag, ".slot"},  32'(slotIdx),   32'(e.slot));
            checkOutput({e.tag, ".key"},   32'(keyOut),    32'(e.key));
            checkOutput({e.tag, ".valid"}, 32'(keyValid),  32'(e.valid));
            checkOutput({e.tag, ".done"},  32'(loadDone),  32'(e.done));
            checkOutput({e.tag, ".ready"}, 32'(loadReady), 32'(e.ready));
        end
    endtask

    task automatic applyStimulus(input logic rs, input logic ls, input logic lv, input logic lb,
                                 input logic se, input logic pa, input string tag,
                                 input logic [1:0] eSlot, input logic [2:0] eKey,
                                 input logic eValid, input logic eDone, input logic eReady);
        expT e;
        reset     = rs;
        loadStart = ls;
        loadValid = lv;
        loadBit   = lb;
        stepEn    = se;
        pause     = pa;
        e.tag   = tag;
        e.slot  = eSlot;
        e.key   = eKey;
        e.valid = eValid;
        e.done  = eDone;
        e.ready = eReady;
        sbQ.push_back(e);
        @(posedge clock);
        #1;
        drainScoreboard();
    endtask

    // Cycle whose outcome is the LOAD state: index 0, key 0, ready high.
    task automatic cycleLoad(input logic rs, input logic ls, input logic lv, input logic lb, input string tag);
        applyStimulus(rs, ls, lv, lb, 1'b0, 1'b0, tag, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Cycle whose outcome is RUN or HOLD showing slot eSlot.
    task automatic cycleRun(input logic se, input logic pa, input logic lv, input logic lb,
                            input string tag, input logic [1:0] eSlot);
        applyStimulus(1'b0, 1'b0, lv, lb, se, pa, tag, eSlot, curKeys[eSlot], 1'b1, 1'b0, 1'b0);
    endtask

    // bits[i] is the i-th serial bit; curKeys must already hold the keys it encodes.
    task automatic loadStream(input logic [11:0] bits, input string tag);
        for (int i = 0; i < 11; i++) begin
            cycleLoad(1'b0, 1'b0, 1'b1, bits[i], tag);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, bits[11], 1'b0, 1'b0, {tag, ".last"},
                      2'd0, curKeys[0], 1'b1, 1'b1, 1'b0);
        pos = 0;
    endtask

    task automatic stepN(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            pos = (pos + 1) % 4;
            cycleRun(1'b1, 1'b0, 1'b0, 1'b0, tag, orderTbl[pos]);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        pos        = 0;
`ifdef KEYSEQ_GRAY_EN
        orderTbl[0] = 2'd0; orderTbl[1] = 2'd1; orderTbl[2] = 2'd3; orderTbl[3] = 2'd2;
`else
        orderTbl[0] = 2'd0; orderTbl[1] = 2'd1; orderTbl[2] = 2'd2; orderTbl[3] = 2'd3;
`endif
        reset = 1'b1; loadStart = 1'b0; loadValid = 1'b0; loadBit = 1'b0; stepEn = 1'b0; pause = 1'b0;

        cycleLoad(1'b1, 1'b0, 1'b0, 1'b0, "reset0");
        cycleLoad(1'b1, 1'b0, 1'b1, 1'b1, "reset1");
        cycleLoad(1'b0, 1'b0, 1'b0, 1'b0, "idleLoad");

        $display("[TB] serial load");
        curKeys[0] = 3'b101; curKeys[1] = 3'b010; curKeys[2] = 3'b111; curKeys[3] = 3'b001;
        loadStream(12'b001_111_010_101, "loadA");
        cycleRun(1'b0, 1'b0, 1'b1, 1'b0, "doneDrop", 2'd0);
        cycleRun(1'b0, 1'b0, 1'b0, 1'b0, "holdIdx", 2'd0);

        $display("[TB] stepping");
        stepN(5, "step");
        for (int g = 0; g < 4 && orderTbl[pos] != 2'd2; g++) begin
            stepN(1, "toSlot2");
        end

        $display("[TB] pause");
        for (int p = 0; p < 3; p++) begin
            cycleRun(1'b1, 1'b1, 1'b0, 1'b0, "hold", 2'd2);
        end
        cycleRun(1'b1, 1'b0, 1'b0, 1'b0, "unpause", 2'd2);
        stepN(1, "resume");

        $display("[TB] reload during run");
        cycleLoad(1'b0, 1'b1, 1'b1, 1'b1, "reloadRun");
        curKeys[0] = 3'b011; curKeys[1] = 3'b100; curKeys[2] = 3'b110; curKeys[3] = 3'b000;
        for (int b = 0; b < 5; b++) begin
            cycleLoad(1'b0, 1'b0, 1'b1, 1'b1, "partialB");
        end
        cycleLoad(1'b0, 1'b1, 1'b1, 1'b1, "restartLoad");
        loadStream(12'b000_110_100_011, "loadB");
        cycleRun(1'b0, 1'b0, 1'b0, 1'b0, "doneDropB", 2'd0);
        stepN(4, "stepB");

        $display("[TB] reset mid-load");
        cycleLoad(1'b0, 1'b1, 1'b0, 1'b0, "reloadC");
        for (int b = 0; b < 7; b++) begin
            cycleLoad(1'b0, 1'b0, 1'b1, 1'b0, "partialC");
        end
        cycleLoad(1'b1, 1'b0, 1'b1, 1'b1, "midReset");
        curKeys[0] = 3'b111; curKeys[1] = 3'b111; curKeys[2] = 3'b111; curKeys[3] = 3'b111;
        loadStream(12'hFFF, "loadOnes");
        cycleRun(1'b0, 1'b0, 1'b0, 1'b0, "doneDropC", 2'd0);
        stepN(4, "stepOnes");

        $display("[TB] reset overrides all inputs");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "resetAll",
                      2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        cycleLoad(1'b0, 1'b0, 1'b0, 1'b0, "postReset");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cute_key_sequencer.md
CUTE_KEY_SEQUENCER -- requirements
Module: cute_key_sequencer

Interface
REQ-001 Parameter NSLOT, default 4: number of key slots; fixed at 4, with a 2-bit slot index.
REQ-002 Parameter KW, default 3: width of each key slot in bits.
REQ-003 Port clock  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 Port load_start  input  1: pulse that requests (re)entry to LOAD.
REQ-006 Port load_valid  input  1: load_bit is valid this cycle.
REQ-007 Port load_bit  input  1: serial key bit; slot0 bit0 first, then ascending bit and slot order.
REQ-008 Port load_ready  output  1: high only in LOAD; a bit transfers when load_valid and load_ready are both high.
REQ-009 Port load_done  output  1: one-cycle pulse when the final key bit is accepted.
REQ-010 Port step_en  input  1: advance the slot index this cycle (RUN only).
REQ-011 Port pause  input  1: enter or stay in HOLD.
REQ-012 Port key_out  output  KW: key word of the current slot.
REQ-013 Port slot_idx  output  2: current slot index.
REQ-014 Port key_valid  output  1: high in RUN and HOLD.

Function
REQ-015 The FSM SHALL have exactly three states: LOAD, RUN and HOLD.
REQ-016 LOAD SHALL accept one bit per handshake into a 12-bit (NSLOT*KW) shift store, tracked by a 4-bit bit counter running 0..11.
REQ-017 Acceptance of bit 11 SHALL, at that same edge:
- move the FSM to RUN;
- clear slot_idx to 0;
- assert load_done for exactly the following cycle.
REQ-018 The LOAD FSM SHALL ignore load_valid whenever load_ready is low.
REQ-019 In RUN, step_en=1 SHALL advance slot_idx at the next edge.
REQ-020 With no macro defined, slot_idx SHALL advance in binary order 0,1,2,3,0.
REQ-021 slot_idx SHALL wrap from its last value back to 0 with no idle cycle.
REQ-022 In RUN, step_en=0 SHALL hold slot_idx.
REQ-023 key_out SHALL equal key slot[slot_idx] combinationally from registers, so key_out changes in the same cycle as slot_idx.
REQ-024 key_out SHALL be 0 in LOAD.
REQ-025 pause=1 in RUN SHALL move the FSM to HOLD at the next edge.
REQ-026 In HOLD, slot_idx and key_out SHALL be frozen regardless of step_en.
REQ-027 pause=0 in HOLD SHALL return the FSM to RUN.
REQ-028 load_start=1 in any state SHALL, at the next edge:
- move the FSM to LOAD;
- clear the bit counter;
- clear slot_idx;
- leave the key store contents intact until they are overwritten.
REQ-029 Priority SHALL be load_start > pause > step_en.
REQ-030 load_start during LOAD SHALL restart the bit count at 0.
REQ-031 If load_start and a valid bit occur in the same cycle, the bit SHALL be discarded.
REQ-032 Simultaneous pause and step_en in RUN SHALL enter HOLD without advancing slot_idx.

Reset
REQ-033 reset=1 SHALL, at the next edge, force the following regardless of other inputs:
- FSM = LOAD;
- bit counter = 0;
- key store = 0;
- slot_idx = 0, key_valid = 0, load_done = 0, key_out = 0;
- load_ready = 1 from the first cycle after reset.
REQ-034 Reset asserted mid-load SHALL discard all bits received so far.
REQ-035 Reset SHALL override load_start and all other inputs.

Configuration
REQ-036 With KEYSEQ_GRAY_EN defined, slot_idx SHALL advance in Gray order 0,1,3,2,0, so exactly one index bit toggles per step.
REQ-037 Without KEYSEQ_GRAY_EN, slot_idx SHALL use binary order per REQ-020; all other behaviour is identical in both builds.

Verification
REQ-038 Scenario 1, serial load:
- stimulus: reset, then 12 contiguous bits encoding slot0=101, slot1=010, slot2=111, slot3=001 (bit stream 1,0,1,0,1,0,1,1,1,1,0,0);
- response: load_done pulses one cycle after bit 11; key_valid=1, slot_idx=0, key_out=101.
REQ-039 Scenario 2, binary stepping:
- stimulus: step_en=1 for 5 cycles after the scenario-1 load;
- response: slot_idx 0,1,2,3,0,1; key_out 101,010,111,001,101,010.
- With KEYSEQ_GRAY_EN: slot_idx 0,1,3,2,0,1; key_out 101,010,001,111,101,010.
REQ-040 Scenario 3, pause:
- stimulus: pause=1 and step_en=1 together at slot_idx=2 for 3 cycles, then pause=0;
- response: slot_idx stays 2 and key_out stays 111 throughout HOLD; stepping resumes from 2.
REQ-041 Scenario 4, reset mid-load:
- stimulus: reset after 7 accepted bits, then a fresh 12-bit load of all ones;
- response: all slots = 111; no load_done occurs before the 12th bit of the fresh load.
REQ-042 Scenario 5, reload during RUN:
- stimulus: load_start in RUN with load_valid=1 in the same cycle;
- response: FSM enters LOAD, key_valid=0, key_out=0; that bit is discarded; the bit count restarts at 0.
